// File: rtl/mandel_coord_gen_pkg.sv
// Shared definitions for the Mandelbrot coordinate source: default geometry,
// FSM encoding and out_dat field offsets used by downstream consumers.
package mandel_coord_gen_pkg;

  localparam int unsigned HRES_DEF = 640;
  localparam int unsigned VRES_DEF = 480;
  localparam int unsigned XW_DEF   = 10;
  localparam int unsigned YW_DEF   = 10;
  localparam int unsigned CW_DEF   = 27;

  localparam int unsigned CR_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Field offsets inside out_dat = {y, x, ci, cr}
  function automatic int unsigned ci_lsb(input int unsigned cw);
    return cw;
  endfunction

  function automatic int unsigned x_lsb(input int unsigned cw);
    return 2 * cw;
  endfunction

  function automatic int unsigned y_lsb(input int unsigned cw, input int unsigned xw);
    return 2 * cw + xw;
  endfunction

endpackage

// File: rtl/mandel_coord_gen_axis_cnt.sv
// One raster axis: index counter with terminal flag plus a coordinate
// accumulator that loads an origin, steps by delta, and reloads on wrap.
module mandel_coord_gen_axis_cnt #(
  parameter int unsigned N  = 640,
  parameter int unsigned IW = 10,
  parameter int unsigned CW = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          load,
  input  logic          step,
  input  logic [CW-1:0] load_val,
  input  logic [CW-1:0] origin,
  input  logic [CW-1:0] delta,
  output logic [IW-1:0] idx,
  output logic [CW-1:0] acc,
  output logic          term_c
);

  assign term_c = (idx == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      acc <= '0;
    end else if (clk_en) begin
      if (load) begin
        idx <= '0;
        acc <= load_val;
      end else if (step) begin
        if (term_c) begin
          idx <= '0;
          acc <= origin;
        end else begin
          idx <= idx + IW'(1);
          acc <= acc + delta;
        end
      end
    end
  end

endmodule

// File: rtl/mandel_coord_gen.sv
// Raster-order pixel coordinate generator: latches frame origin/step on start
// and streams {y, x, ci, cr} words over a valid/ready interface.
module mandel_coord_gen
  import mandel_coord_gen_pkg::*;
#(
  parameter  int unsigned HRES = HRES_DEF,
  parameter  int unsigned VRES = VRES_DEF,
  parameter  int unsigned XW   = XW_DEF,
  parameter  int unsigned YW   = YW_DEF,
  parameter  int unsigned CW   = CW_DEF,
  localparam int unsigned DW   = YW + XW + 2 * CW
) (
  input  logic          clk,
  input  logic          clk_en,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] dx,
  input  logic [CW-1:0] dy,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CI_LSB = ci_lsb(CW);
  localparam int unsigned X_LSB  = x_lsb(CW);
  localparam int unsigned Y_LSB  = y_lsb(CW, XW);

  state_t        state_q;
  state_t        state_d;
  logic          done_q;
  logic          done_d;
  logic [CW-1:0] x0_q;
  logic [CW-1:0] y0_q;
  logic [CW-1:0] dx_q;
  logic [CW-1:0] dy_q;

  logic          load_c;
  logic          adv_c;
  logic [XW-1:0] x_idx;
  logic [YW-1:0] y_idx;
  logic [CW-1:0] cr_acc;
  logic [CW-1:0] ci_acc;
  logic          x_term_c;
  logic          y_term_c;

  assign load_c = (state_q == ST_IDLE) && start && !abort;
  assign adv_c  = (state_q == ST_RUN) && out_rdy;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) state_d = ST_RUN;
      end
      ST_RUN: begin
        // abort wins over a final handshake, suppressing done
        if (abort) begin
          state_d = ST_IDLE;
        end else if (out_rdy && x_term_c && y_term_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      done_q  <= done_d;
      if (load_c) begin
        x0_q <= x0;
        y0_q <= y0;
        dx_q <= dx;
        dy_q <= dy;
      end
    end
  end

  mandel_coord_gen_axis_cnt #(
    .N  (HRES),
    .IW (XW),
    .CW (CW)
  ) u_x_axis (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .load     (load_c),
    .step     (adv_c),
    .load_val (x0),
    .origin   (x0_q),
    .delta    (dx_q),
    .idx      (x_idx),
    .acc      (cr_acc),
    .term_c   (x_term_c)
  );

  mandel_coord_gen_axis_cnt #(
    .N  (VRES),
    .IW (YW),
    .CW (CW)
  ) u_y_axis (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .load     (load_c),
    .step     (adv_c && x_term_c),
    .load_val (y0),
    .origin   (y0_q),
    .delta    (dy_q),
    .idx      (y_idx),
    .acc      (ci_acc),
    .term_c   (y_term_c)
  );

  assign out_dat[CR_LSB +: CW] = cr_acc;
  assign out_dat[CI_LSB +: CW] = ci_acc;
  assign out_dat[X_LSB  +: XW] = x_idx;
  assign out_dat[Y_LSB  +: YW] = y_idx;

  assign out_vld = (state_q == ST_RUN);
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;

endmodule
